fsm_processor_sender: RTL
=========================

Name: fsm_processor_sender

Overview:
Processor-side transmitter for the synchronous SEND/data link. It queues words written by local processor logic in a small FIFO and drives the peripheral receiver. For each word it raises SEND_proc for a fixed hold window with the word stable on outputData_proc, then inserts an idle gap. It is the driving end of the link: its SEND_proc and outputData_proc connect to the peripheral's SEND and input data ports.

Parameters:
DATA_WIDTH, 32, width of transferred word
DEPTH, 4, FIFO entries; power of 2, >= 2
HOLD_CYCLES, 2, cycles SEND_proc stays high per word; >= 1
GAP_CYCLES, 1, cycles SEND_proc stays low between words; >= 0
CNT_WIDTH, 16, width of sent-word counter

Ports:
clk_proc  input  1  clock; all logic on posedge
rst_proc  input  1  synchronous, active-high reset
wrEn_proc  input  1  write request from processor logic
wrData_proc  input  DATA_WIDTH  word to enqueue
full_proc  output  1  FIFO full (combinational from count)
empty_proc  output  1  FIFO empty (combinational from count)
overflow_proc  output  1  sticky: write attempted while full
busy_proc  output  1  state != IDLE or FIFO not empty
SEND_proc  output  1  registered; high while a word is presented
outputData_proc  output  DATA_WIDTH  registered word driven to the peripheral
wordsSent_proc  output  CNT_WIDTH  count of completed words; wraps

Behaviour:
- Reset, sampled on posedge with rst_proc=1: FSM=IDLE; FIFO pointers and count=0; SEND_proc=0; outputData_proc=0; overflow_proc=0; wordsSent_proc=0; hold/gap counters=0. Reset takes priority over every other event. Reset during SEND forces SEND_proc low at that edge and discards the in-flight word and all queued words.
- FIFO write: on an edge with wrEn_proc=1 and full_proc=0, the word is stored at the tail.
- With wrEn_proc=1 and full_proc=1, the word is dropped and overflow_proc is set. Full is evaluated before any pop in the same cycle, so a same-cycle pop does not rescue the write.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH.
- States: IDLE, SEND, GAP.
- IDLE:
  - If empty_proc=0: pop the head into outputData_proc, set SEND_proc=1, load holdCnt=HOLD_CYCLES-1, go to SEND.
  - Otherwise stay in IDLE with SEND_proc=0.
- SEND:
  - SEND_proc=1 and outputData_proc held stable.
  - If holdCnt != 0: decrement.
  - If holdCnt == 0: increment wordsSent_proc. Then:
    - If GAP_CYCLES > 0: SEND_proc=0, load gapCnt=GAP_CYCLES-1, go to GAP.
    - If GAP_CYCLES == 0 and the FIFO is not empty: pop the next word directly, keep SEND_proc=1, reload holdCnt (back-to-back transfer).
    - Otherwise: SEND_proc=0, go to IDLE.
- GAP:
  - SEND_proc=0.
  - If gapCnt != 0: decrement.
  - If gapCnt == 0: go to IDLE (the next word, if any, starts on the following edge).
- Timing:
  - A write into an empty FIFO in IDLE at edge E0 produces SEND_proc=1 after edge E1.
  - SEND_proc is high for exactly HOLD_CYCLES cycles.
  - Minimum word period is HOLD_CYCLES+GAP_CYCLES+1 cycles, or HOLD_CYCLES when GAP_CYCLES=0.
- outputData_proc keeps the last word after SEND_proc falls and changes only on a pop or on reset.
- wordsSent_proc wraps from 2^CNT_WIDTH-1 to 0 without any flag.
- overflow_proc clears only on reset.

Optional Feature:
Macro: SENDER_ACK_EN.
- When defined:
  - Adds input ACK_proc (1 bit) and output timeout_proc (1 bit, sticky, cleared by reset).
  - In SEND, the word completes at the first edge where ACK_proc=1. SEND_proc is always high for at least 1 cycle.
  - HOLD_CYCLES acts as a timeout. If holdCnt reaches 0 with ACK_proc=0, set timeout_proc, do not increment wordsSent_proc, and leave SEND as normal (GAP or IDLE).
  - If ACK_proc=1 arrives on the timeout edge, the ACK wins: the word is counted and no timeout is flagged.
- When undefined: neither port exists, and SEND lasts exactly HOLD_CYCLES cycles as above.

Test Plan:
- Single word: reset, then one write of 0xDEADBEEF at E0 -> SEND_proc high for cycles E1..E2 (HOLD_CYCLES=2) with outputData_proc=0xDEADBEEF. Then low 1 gap cycle, wordsSent_proc=1, busy_proc=0 afterwards, outputData_proc still 0xDEADBEEF.
- Burst and overflow: 6 consecutive writes 0x1..0x6 while in IDLE with DEPTH=4 -> words 0x1..0x5 are transmitted in order (the first pop frees one slot) and 0x6 is dropped; overflow_proc=1, full_proc seen high, wordsSent_proc=5.
- Back-to-back: GAP_CYCLES=0, HOLD_CYCLES=1, 3 words queued -> SEND_proc high for 3 consecutive cycles with outputData_proc changing every cycle, then SEND_proc=0.
- Reset mid-transfer: rst_proc=1 during the second SEND cycle with 2 words queued -> next edge gives SEND_proc=0, outputData_proc=0, empty_proc=1, wordsSent_proc=0, and no further SEND activity.
- Counter wrap: CNT_WIDTH=2, send 5 words -> wordsSent_proc sequence 1,2,3,0,1.
- ACK mode (SENDER_ACK_EN, HOLD_CYCLES=4):
  - ACK_proc pulses on the 2nd SEND cycle -> SEND_proc high exactly 2 cycles and the word is counted.
  - With no ACK -> SEND_proc high 4 cycles, timeout_proc=1, and the count is unchanged.

Source files
------------

// File: rtl/fsm_processor_sender_if.sv
// Processor/link bundle for fsm_processor_sender.
// ACK_proc and timeout_proc exist only when SENDER_ACK_EN is defined.
interface fsm_processor_sender_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  wrEn_proc;
    logic [DATA_WIDTH-1:0] wrData_proc;
    logic                  full_proc;
    logic                  empty_proc;
    logic                  overflow_proc;
    logic                  busy_proc;
    logic                  SEND_proc;
    logic [DATA_WIDTH-1:0] outputData_proc;
    logic [CNT_WIDTH-1:0]  wordsSent_proc;
`ifdef SENDER_ACK_EN
    logic                  ACK_proc;
    logic                  timeout_proc;

    modport master (
        output wrEn_proc, wrData_proc, ACK_proc,
        input  full_proc, empty_proc, overflow_proc, busy_proc,
               SEND_proc, outputData_proc, wordsSent_proc, timeout_proc
    );
    modport slave (
        input  wrEn_proc, wrData_proc, ACK_proc,
        output full_proc, empty_proc, overflow_proc, busy_proc,
               SEND_proc, outputData_proc, wordsSent_proc, timeout_proc
    );
`else
    modport master (
        output wrEn_proc, wrData_proc,
        input  full_proc, empty_proc, overflow_proc, busy_proc,
               SEND_proc, outputData_proc, wordsSent_proc
    );
    modport slave (
        input  wrEn_proc, wrData_proc,
        output full_proc, empty_proc, overflow_proc, busy_proc,
               SEND_proc, outputData_proc, wordsSent_proc
    );
`endif
endinterface

// File: rtl/fsm_processor_sender.sv
// Processor-side SEND/data link transmitter: FIFO-buffered words, fixed SEND hold window, idle gap.
// Optional handshake mode: define SENDER_ACK_EN (ACK_proc ends a word early, HOLD_CYCLES becomes a timeout).
module fsm_processor_sender #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic                   clk_proc,
    input logic                   rst_proc,
    fsm_processor_sender_if.slave bus
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  send_q, send_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d;
    logic                  ovf_q, ovf_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [GAP_W-1:0]      gap_q, gap_d;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;
    logic word_done_c;
    logic word_ok_c;

    assign full_c  = (fill_q == FILL_W'(DEPTH));
    assign empty_c = (fill_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    assign push_c  = bus.wrEn_proc && !full_c;

`ifdef SENDER_ACK_EN
    logic timeout_q, timeout_d;

    assign word_done_c = bus.ACK_proc || (hold_q == '0);
    assign word_ok_c   = bus.ACK_proc;
    assign bus.timeout_proc = timeout_q;
`else
    assign word_done_c = (hold_q == '0);
    assign word_ok_c   = 1'b1;
`endif

    // FIFO storage and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        fill_d   = fill_q + FILL_W'(push_c) - FILL_W'(pop_c);
        ovf_d    = ovf_q | (bus.wrEn_proc & full_c);
        if (push_c) begin
            mem_d[wr_ptr_q] = bus.wrData_proc;
        end
    end

    // Transmit FSM: next state and registered link outputs
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        data_d  = data_q;
        sent_d  = sent_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        pop_c   = 1'b0;
`ifdef SENDER_ACK_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                send_d = 1'b0;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    send_d  = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (word_done_c) begin
                    if (word_ok_c) begin
                        sent_d = sent_q + CNT_WIDTH'(1);
                    end
`ifdef SENDER_ACK_EN
                    else begin
                        timeout_d = 1'b1;
                    end
`endif
                    if (GAP_CYCLES > 0) begin
                        send_d  = 1'b0;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end else if (!empty_c) begin
                        // Back-to-back: next word goes out with no idle cycle
                        pop_c  = 1'b1;
                        send_d = 1'b1;
                        data_d = mem_q[rd_ptr_q];
                        hold_d = HOLD_W'(HOLD_CYCLES - 1);
                    end else begin
                        send_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_GAP: begin
                send_d = 1'b0;
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_proc) begin
        if (rst_proc) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            send_q   <= 1'b0;
            data_q   <= '0;
            sent_q   <= '0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
            gap_q    <= '0;
`ifdef SENDER_ACK_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            send_q   <= send_d;
            data_q   <= data_d;
            sent_q   <= sent_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
`ifdef SENDER_ACK_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // Storage array needs no reset; occupancy is tracked by the pointers and fill count
    always_ff @(posedge clk_proc) begin
        mem_q <= mem_d;
    end

    assign bus.full_proc       = full_c;
    assign bus.empty_proc      = empty_c;
    assign bus.overflow_proc   = ovf_q;
    assign bus.busy_proc       = (state_q != ST_IDLE) || !empty_c;
    assign bus.SEND_proc       = send_q;
    assign bus.outputData_proc = data_q;
    assign bus.wordsSent_proc  = sent_q;

endmodule
